shift_arbiter_2ch: RTL

Two-requester controller that shares one 8-bit logarithmic left shifter (A shifted left by B) between two clients, such as the ALU issue path and the address-generation path. Each client presents operands through a valid/ready handshake. The arbiter grants round-robin, drives the shared shifter from latched operands, and returns the result with a requester tag through a valid/ready response channel. It sits between the ALU decode stage and the shared shift datapath.

---
 rtl/shift_ctrl_pkg.sv | 16 +
 rtl/shift_arbiter_2ch_if.sv | 44 ++++
 rtl/shl8_datapath.sv | 16 +
 rtl/shift_arbiter_2ch.sv | 105 ++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Optional overflow flag is controlled by SHIFT_OVF_FLAG_EN (see shift_arbiter_2ch).
package shift_ctrl_pkg;

   localparam int DW = 8;
   localparam int SW = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/shift_arbiter_2ch_if.sv
// Request/response bundle between the two clients, the arbiter and the result consumer.
// res_ovf exists only when SHIFT_OVF_FLAG_EN is defined.
interface shift_arbiter_2ch_if;
   import shift_ctrl_pkg::*;

   logic          req0_valid;
   logic          req0_ready;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic          req1_valid;
   logic          req1_ready;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   req_id_t       res_id;
`ifdef SHIFT_OVF_FLAG_EN
   logic          res_ovf;
`endif

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id
`ifdef SHIFT_OVF_FLAG_EN
      , input res_ovf
`endif
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id
`ifdef SHIFT_OVF_FLAG_EN
      , output res_ovf
`endif
   );

endinterface

// File: rtl/shl8_datapath.sv
// Combinational 8-bit logarithmic left shifter: three mux stages shifting by 1, 2 and 4.
module shl8_datapath
   import shift_ctrl_pkg::*;
(
   output logic [DW-1:0] res,
   input  logic [DW-1:0] a,
   input  logic [SW-1:0] b
);

   logic [DW-1:0] s1, s2;

   assign s1  = b[0] ? {a[DW-2:0],  1'b0}    : a;
   assign s2  = b[1] ? {s1[DW-3:0], 2'b00}   : s1;
   assign res = b[2] ? {s2[DW-5:0], 4'b0000} : s2;

endmodule

// File: rtl/shift_arbiter_2ch.sv
// Round-robin arbiter sharing one 8-bit left shifter between two requesters.
// Define SHIFT_OVF_FLAG_EN to add the registered res_ovf (nonzero bits shifted out) output.
module shift_arbiter_2ch
   import shift_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   shift_arbiter_2ch_if.slave bus,
   output logic               busy
);

   state_t        state_q, state_d;
   req_id_t       last_id_q, grant, id_p0, res_id_q;
   logic          any_valid, idle, accept;
   logic [DW-1:0] a_p0, b_p0, shl_out, res_next, res_data_q;

`ifdef SHIFT_OVF_FLAG_EN
   logic          res_ovf_q;

   function automatic logic ovf_flag(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (|b[DW-1:SW])
         return |a;
      return |(a & ~({DW{1'b1}} >> b[SW-1:0]));
   endfunction
`endif

   // Arbitration: a tie goes to the requester that was not served last.
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant = ~last_id_q;
      else if (bus.req1_valid)
         grant = 1'b1;
   end

   assign any_valid      = bus.req0_valid | bus.req1_valid;
   assign idle           = (state_q == IDLE);
   assign accept         = idle && any_valid;
   assign bus.req0_ready = accept && (grant == 1'b0);
   assign bus.req1_ready = accept && (grant == 1'b1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_id_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (accept)
            last_id_q <= grant;
      end
   end

   // Stage p0: operands captured on handshake
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0  <= grant ? bus.req1_a : bus.req0_a;
         b_p0  <= grant ? bus.req1_b : bus.req0_b;
         id_p0 <= grant;
      end
   end

   shl8_datapath u_shl (
      .res (shl_out),
      .a   (a_p0),
      .b   (b_p0[SW-1:0])
   );

   assign res_next = (|b_p0[DW-1:SW]) ? '0 : shl_out;

   // Stage p1: result registered in EXEC, held through RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data_q <= '0;
         res_id_q   <= 1'b0;
`ifdef SHIFT_OVF_FLAG_EN
         res_ovf_q  <= 1'b0;
`endif
      end else if (state_q == EXEC) begin
         res_data_q <= res_next;
         res_id_q   <= id_p0;
`ifdef SHIFT_OVF_FLAG_EN
         res_ovf_q  <= ovf_flag(a_p0, b_p0);
`endif
      end
   end

   assign bus.res_valid = (state_q == RESP);
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
`ifdef SHIFT_OVF_FLAG_EN
   assign bus.res_ovf   = res_ovf_q;
`endif
   assign busy          = !idle;

endmodule
